// File: rtl/spram_pkg.sv
// Shared types for the single-port RAM controller: write-response modes,
// controller FSM states and the byte-enable width derivation.
package spram_pkg;

    typedef enum logic [1:0] {
        NORMAL_WRITE      = 2'd0,
        TRANSPARENT_WRITE = 2'd1,
        READ_BEFORE_WRITE = 2'd2
    } write_mode_e;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_CLEAR = 2'd1,
        ST_READY = 2'd2
    } state_e;

    function automatic int be_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/spram_core.sv
// Byte-enabled storage array with a registered 1-cycle read port that can
// return either the pre-write word or the post-write merged word.
module spram_core
    import spram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = be_width(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [BE_WIDTH-1:0]   byte_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic                  rd_merged,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] merged_word;

    always_comb begin
        old_word    = mem[addr];
        merged_word = old_word;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (wr_en && byte_en[i]) begin
                merged_word[8*i +: 8] = wr_data[8*i +: 8];
            end
        end
    end

    // The array itself is never reset; only the read register is.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (wr_en && byte_en[i]) begin
                mem[addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_merged ? merged_word : old_word;
        end
    end

endmodule

// File: rtl/spram_ctrl.sv
// Single-port RAM controller: reset/clear/ready sequencing, request
// acceptance, write-response modes and an optional read-data register.
module spram_ctrl
    import spram_pkg::*;
#(
    parameter int          ADDR_WIDTH = 10,
    parameter int          DATA_WIDTH = 32,
    parameter int          OUTPUT_REG = 0,
    parameter write_mode_e WRITE_MODE = NORMAL_WRITE,
    parameter int          INIT_CLEAR = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wr,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_byte_en,
    output logic                    rd_valid,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    init_busy
);

    localparam int BE_WIDTH = be_width(DATA_WIDTH);

    state_e                state;
    state_e                state_next;
    logic [ADDR_WIDTH:0]   clr_cnt;
    logic [ADDR_WIDTH:0]   clr_cnt_inc;
    logic                  clearing;
    logic                  accept;
    logic                  rd_issue;
    logic                  rd_merged;
    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic [BE_WIDTH-1:0]   mem_byte_en;
    logic [DATA_WIDTH-1:0] core_rd_data;
    logic                  valid_s1;
    logic                  rd_valid_int;
    logic [DATA_WIDTH-1:0] rd_data_int;

    assign clr_cnt_inc = clr_cnt + {{ADDR_WIDTH{1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RESET;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RESET: state_next = (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
            ST_CLEAR: begin
                if (clr_cnt_inc[ADDR_WIDTH]) begin
                    state_next = ST_READY;
                end
            end
            ST_READY: state_next = ST_READY;
            default:  state_next = ST_RESET;
        endcase
    end

    // The counter parks with its MSB set once the last word is cleared.
    always_ff @(posedge clk) begin
        if (rst || state == ST_RESET) begin
            clr_cnt <= '0;
        end else if (state == ST_CLEAR && !clr_cnt[ADDR_WIDTH]) begin
            clr_cnt <= clr_cnt_inc;
        end
    end

    assign req_ready = (state == ST_READY) && !rst;
    assign init_busy = (state != ST_READY) || rst;
    assign clearing  = (state == ST_CLEAR) && !rst;
    assign accept    = req_valid && req_ready;

    assign mem_wr_en   = clearing || (accept && req_wr);
    assign mem_addr    = clearing ? clr_cnt[ADDR_WIDTH-1:0] : addr;
    assign mem_wr_data = clearing ? '0 : wr_data;
    assign mem_byte_en = clearing ? '1 : wr_byte_en;
    assign rd_issue    = accept && (!req_wr || WRITE_MODE != NORMAL_WRITE);
    assign rd_merged   = (WRITE_MODE == TRANSPARENT_WRITE);

    spram_core #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .BE_WIDTH   (BE_WIDTH)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (mem_wr_en),
        .byte_en   (mem_byte_en),
        .addr      (mem_addr),
        .wr_data   (mem_wr_data),
        .rd_en     (rd_issue),
        .rd_merged (rd_merged),
        .rd_data   (core_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_s1 <= 1'b0;
        end else begin
            valid_s1 <= rd_issue;
        end
    end

    generate
        if (OUTPUT_REG != 0) begin : g_out_reg
            logic                  valid_s2;
            logic [DATA_WIDTH-1:0] data_s2;

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_s2 <= 1'b0;
                    data_s2  <= '0;
                end else begin
                    valid_s2 <= valid_s1;
                    if (valid_s1) begin
                        data_s2 <= core_rd_data;
                    end
                end
            end

            assign rd_valid_int = valid_s2;
            assign rd_data_int  = data_s2;
        end else begin : g_no_out_reg
            assign rd_valid_int = valid_s1;
            assign rd_data_int  = core_rd_data;
        end
    endgenerate

    // Outputs read as idle for the whole time rst is held, including its first cycle.
    assign rd_valid = rd_valid_int && !rst;
    assign rd_data  = rst ? '0 : rd_data_int;

endmodule
